// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: ROM request/response, redirect input and the
// instruction-buffer head handshake toward the decoder.
interface fetch_unit_if #(
    parameter int ADDR_W = 20
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              misalign;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_ready;

    modport master (
        output rom_req, rom_addr, misalign, inst_valid, inst, inst_pc,
        input  rom_inst, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  rom_req, rom_addr, misalign, inst_valid, inst, inst_pc,
        output rom_inst, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads to a 1-cycle-latency ROM, buffers
// {inst, pc} pairs in a small FIFO and restarts cleanly on redirect.
module fetch_unit #(
    parameter int          ADDR_W   = 20,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d, inflight_pc_q;
    logic              inflight_q, misalign_q, misalign_d, valid_q;
    logic              pop, kill, wr, issue;
    logic [CNT_W:0]    occ;

    // A redirect in the response cycle kills the returning word.
    assign kill  = bus.redirect;
    assign pop   = valid_q & bus.inst_ready;
    assign wr    = inflight_q & ~kill & ~rst;
    // Slots already committed: buffered + in flight, minus the one leaving now.
    assign occ   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign issue = ~rst & ~bus.redirect & (occ < DEPTH_C);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = bus.redirect & (|bus.redirect_pc[1:0]);
        if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
        if (wr)    tail_d = tail_q + PTR_W'(1);
        if (pop)   head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= issue;
            misalign_q <= misalign_d;
            valid_q    <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= fetch_pc_q;
        if (wr)    mem_q[tail_q] <= '{inst: bus.rom_inst, pc: inflight_pc_q};
    end

    assign bus.rom_req    = issue;
    assign bus.rom_addr   = fetch_pc_q[ADDR_W+1:2];
    assign bus.misalign   = misalign_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = mem_q[head_q].inst;
    assign bus.inst_pc    = mem_q[head_q].pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (default, and DEPTH=2 at the top of
// the address space) checked one at a time against a queue-based model.
module tb_fetch_unit;
    localparam int AW = 20;

    logic        clk = 1'b0;
    logic        rst0, rst1, sel;
    logic        rdy, redir;
    logic [31:0] rpc, rom_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW)) b0 ();
    fetch_unit_if #(.ADDR_W(AW)) b1 ();

    assign b0.rom_inst = rom_inst;  assign b1.rom_inst = rom_inst;
    assign b0.redirect = redir;     assign b1.redirect = redir;
    assign b0.redirect_pc = rpc;    assign b1.redirect_pc = rpc;
    assign b0.inst_ready = rdy;     assign b1.inst_ready = rdy;

    fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst0), .bus(b0));
    fetch_unit #(.ADDR_W(AW), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst1), .bus(b1));

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_infl_pc, m_reset_pc;
    bit          m_infl, m_mis;
    int          m_depth;

    // observed snapshot of the current cycle
    logic        g_req, g_val, g_mis;
    logic [31:0] g_addr, g_pc, g_inst;

    function automatic logic [31:0] tag(input logic [AW-1:0] a);
        return {12'hA5C, a};
    endfunction

    function automatic logic [AW-1:0] waddr(input logic [31:0] pc);
        return AW'(pc >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic mreset();
        mq.delete();
        m_pc   = m_reset_pc;
        m_infl = 0;
        m_mis  = 0;
    endtask

    task automatic cyc();
        bit   pop, e_req, r;
        int   occ;
        logic [AW-1:0] l_addr;
        @(negedge clk);
        r      = sel ? rst1 : rst0;
        g_req  = sel ? b1.rom_req : b0.rom_req;
        g_addr = 32'(sel ? b1.rom_addr : b0.rom_addr);
        g_val  = sel ? b1.inst_valid : b0.inst_valid;
        g_pc   = sel ? b1.inst_pc : b0.inst_pc;
        g_inst = sel ? b1.inst : b0.inst;
        g_mis  = sel ? b1.misalign : b0.misalign;
        pop    = (mq.size() != 0) && rdy;
        occ    = mq.size() + int'(m_infl) - int'(pop);
        e_req  = !r && !redir && (occ < m_depth);
        chk("rom_req", 32'(g_req), 32'(e_req));
        if (e_req) chk("rom_addr", g_addr, 32'(waddr(m_pc)));
        chk("inst_valid", 32'(g_val), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst", g_inst, mq[0].inst);
            chk("inst_pc", g_pc, mq[0].pc);
        end
        chk("misalign", 32'(g_mis), 32'(m_mis));
        l_addr = AW'(g_addr);
        @(posedge clk);
        if (r) begin
            mreset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl && !redir) mq.push_back('{inst: tag(waddr(m_infl_pc)), pc: m_infl_pc});
            m_mis = redir && (rpc[1:0] != 2'b00);
            if (redir) begin
                mq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        #1 rom_inst = g_req ? tag(l_addr) : $urandom();
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 22) == 0);
            rpc   = $urandom();
            if (sel) rst1 = ($urandom_range(0, 96) == 0);
            else     rst0 = ($urandom_range(0, 96) == 0);
            cyc();
        end
        redir = 0; rst0 = 0; rst1 = 0;
    endtask

    initial begin
        int nreq, nv;
        sel = 0; rst0 = 1; rst1 = 1; rdy = 0; redir = 0; rpc = 0; rom_inst = 0;
        m_depth = 4; m_reset_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 mreset();
        cyc();
        chk("reset_req", 32'(g_req), 32'd0);
        chk("reset_valid", 32'(g_val), 32'd0);

        // reset release, streaming at full rate
        rst0 = 0; rdy = 1;
        cyc(); chk("rel_addr0", g_addr, 32'd0);
        cyc(); chk("rel_addr1", g_addr, 32'd1);
        cyc(); chk("first_valid", 32'(g_val), 32'd1); chk("first_pc", g_pc, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(); chk("stream_valid", 32'(g_val), 32'd1); chk("stream_pc", g_pc, 32'(k * 4));
        end

        // consumer stalled: buffer fills to DEPTH then fetch stops
        rst0 = 1; cyc(); rst0 = 0; rdy = 0; nreq = 0;
        repeat (8) begin cyc(); nreq += int'(g_req); end
        chk("stall_reqs", 32'(nreq), 32'd4);
        rdy = 1;
        for (int k = 0; k < 8; k++) begin
            cyc(); chk("drain_pc", g_pc, 32'(k * 4));
        end

        // redirect with 3 buffered and one in flight
        rst0 = 1; cyc(); rst0 = 0; rdy = 0;
        repeat (4) cyc();
        redir = 1; rpc = 32'h100; cyc();
        redir = 0; rdy = 1;
        cyc(); chk("rd_valid_r1", 32'(g_val), 32'd0);
               chk("rd_req_r1", 32'(g_req), 32'd1);
               chk("rd_addr_r1", g_addr, 32'h40);
        cyc(); chk("rd_valid_r2", 32'(g_val), 32'd0);
        cyc(); chk("rd_valid_r3", 32'(g_val), 32'd1); chk("rd_pc_r3", g_pc, 32'h100);

        // misaligned redirect
        redir = 1; rpc = 32'h103; cyc();
        redir = 0;
        cyc(); chk("mis_r1", 32'(g_mis), 32'd1);
        cyc(); chk("mis_r2", 32'(g_mis), 32'd0);
        cyc(); chk("mis_pc", g_pc, 32'h100);

        // redirect coincident with a pop
        repeat (3) cyc();
        redir = 1; rpc = 32'h200; cyc();
        chk("pop_at_redir", 32'(g_val & rdy), 32'd1);
        redir = 0;
        repeat (2) cyc();
        cyc(); chk("post_pop_pc", g_pc, 32'h200);

        // second instance: DEPTH=2, reset PC near the top of the space
        rst0 = 1; rst1 = 1; cyc();
        sel = 1; m_depth = 2; m_reset_pc = 32'hFFFF_FFF8; mreset();
        cyc();
        rst1 = 0; rdy = 1;
        cyc(); chk("wrap_addr0", g_addr, 32'hF_FFFE);
        cyc(); chk("wrap_addr1", g_addr, 32'hF_FFFF);
        cyc(); chk("wrap_pc0", g_pc, 32'hFFFF_FFF8); chk("wrap_addr2", g_addr, 32'h0);
        cyc(); chk("wrap_pc1", g_pc, 32'hFFFF_FFFC);
        cyc(); chk("wrap_pc2", g_pc, 32'h0000_0000);
        nv = 0;
        repeat (6) begin cyc(); nv += int'(g_val); end
        chk("thru_depth2", 32'(nv), 32'd6);
        rst1 = 1; cyc();
        cyc(); chk("rst_clears_valid", 32'(g_val), 32'd0);
        rst1 = 0;
        rand_phase(700);

        // back to the default instance for random traffic
        rst0 = 1; rst1 = 1; cyc();
        sel = 0; m_depth = 4; m_reset_pc = 32'h0; mreset();
        cyc();
        rst0 = 0;
        rand_phase(900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
